// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmitter between NUM_REQ requesters.
// Each request and its byte are latched, served round-robin, launched with a
// one-cycle start strobe, and separated by a programmable idle gap.
module uart_tx_scheduler #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int GAP_CYCLES = 16
) (
   input  logic                            clock,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              req_pulse,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   input  logic                            tx_busy,
   input  logic                            tx_done,
   output logic                            tx_start,
   output logic [DATA_WIDTH-1:0]           tx_data,
   output logic [$clog2(NUM_REQ)-1:0]      grant_id,
   output logic [NUM_REQ-1:0]              pending,
   output logic                            drop_pulse
);

   localparam int IDW = $clog2(NUM_REQ);
   localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GAP} state_t;

   state_t                               state_q;
   logic [NUM_REQ-1:0]                   pending_q, pending_d;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   hold_q, hold_d;
   logic                                 drop_q, drop_d;
   logic [IDW-1:0]                       ptr_q, grant_q, winner, cand;
   logic [DATA_WIDTH-1:0]                txd_q;
   logic                                 start_q;
   logic [GW-1:0]                        gap_q;
   logic                                 found;
   int                                   idx;

   // Round-robin search starting one past the last winner.
   always_comb begin
      winner = ptr_q;
      found  = 1'b0;
      idx    = 0;
      cand   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx  = (int'(ptr_q) + k) % NUM_REQ;
         cand = IDW'(idx);
         if (!found && pending_q[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   // Request capture: a pulse on the requester being launched this cycle
   // re-arms it with the new byte; the launched frame already holds the old one.
   always_comb begin
      pending_d = pending_q;
      hold_d    = hold_q;
      drop_d    = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (state_q == LAUNCH && grant_q == IDW'(i)) pending_d[i] = 1'b0;
         if (req_pulse[i]) begin
            if (!pending_q[i] || (state_q == LAUNCH && grant_q == IDW'(i))) begin
               pending_d[i] = 1'b1;
               hold_d[i]    = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
               drop_d = 1'b1;
            end
         end
      end
   end

   // Request/holding registers and the drop flag.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         pending_q <= '0;
         hold_q    <= '0;
         drop_q    <= 1'b0;
      end else begin
         pending_q <= pending_d;
         hold_q    <= hold_d;
         drop_q    <= drop_d;
      end
   end

   // Launch sequencer with registered strobe, byte and grant.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= IDW'(NUM_REQ - 1);
         grant_q <= '0;
         txd_q   <= '0;
         start_q <= 1'b0;
         gap_q   <= '0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (|pending_q && !tx_busy) begin
                  state_q <= LAUNCH;
                  grant_q <= winner;
                  ptr_q   <= winner;
                  txd_q   <= hold_q[winner];
                  start_q <= 1'b1;
               end
            end
            LAUNCH: state_q <= WAIT_DONE;
            WAIT_DONE: begin
               if (tx_done) begin
                  gap_q   <= '0;
                  state_q <= (GAP_CYCLES == 0) ? IDLE : GAP;
               end
            end
            GAP: begin
               if (gap_q == GAP_LAST) begin
                  gap_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  gap_q <= gap_q + GW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_start   = start_q;
   assign tx_data    = txd_q;
   assign grant_id   = grant_q;
   assign pending    = pending_q;
   assign drop_pulse = drop_q;

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmitter between NUM_REQ requesters, e.g. debounced button send pulses that each carry a byte.
- Latches each request and its byte, then grants round-robin.
- Sequences the transmitter with a one-cycle start strobe and waits for frame completion.
- Enforces a minimum idle gap between frames.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 8, payload width per frame
- GAP_CYCLES, 16, idle clocks inserted after each tx_done; 0 = no gap

Ports:
- clock  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- req_pulse  input  NUM_REQ  one-cycle send request per requester
- req_data  input  NUM_REQ*DATA_WIDTH  payload; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]; sampled only on that requester's req_pulse
- tx_busy  input  1  transmitter busy
- tx_done  input  1  one-cycle frame-complete pulse from transmitter
- tx_start  output  1  one-cycle start strobe to transmitter
- tx_data  output  DATA_WIDTH  byte for the current frame
- grant_id  output  $clog2(NUM_REQ)  index of the requester being served
- pending  output  NUM_REQ  latched, not-yet-launched requests
- drop_pulse  output  1  one-cycle flag: a request was lost

Behaviour:
- Reset: rst_n low at a clock edge forces the following.
  - State IDLE; pending=0; tx_start=0; tx_data=0; grant_id=0; drop_pulse=0.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.
  - Gap counter=0; holding registers=0.
  - Reset asserted mid-frame abandons the frame; the block does not wait for tx_done.
- Request capture, per requester i:
  - req_pulse[i] with pending[i]=0 sets pending[i] next cycle and loads hold[i] from req_data.
  - req_pulse[i] with pending[i]=1, and i not launching this cycle, keeps the old hold[i]. drop_pulse is 1 next cycle.
  - req_pulse[i] in the same cycle i is launched is accepted, not dropped. pending[i] is 1 next cycle and hold[i] takes the new byte. The launched frame uses the old byte.
  - Several simultaneous pulses are all captured independently.
- Arbitration: round-robin. Search begins at pointer+1 modulo NUM_REQ; the first set pending bit wins. The pointer updates to the winner at launch.
- FSM states IDLE, LAUNCH, WAIT_DONE, GAP:
  - IDLE: moves to LAUNCH when pending!=0 and tx_busy=0. The winner is registered into grant_id and tx_data on that edge.
  - LAUNCH: one cycle with tx_start=1; pending[grant_id] cleared at the end of this cycle. Always moves to WAIT_DONE.
  - WAIT_DONE: waits for tx_done=1, then moves to GAP, or to IDLE if GAP_CYCLES=0. tx_done seen in any other state is ignored.
  - GAP: counts GAP_CYCLES clocks from 0 to GAP_CYCLES-1, then moves to IDLE. New requests are still captured during the gap.
- Outputs:
  - tx_start is asserted only in LAUNCH.
  - tx_data and grant_id are registered and hold stable from LAUNCH until the next IDLE→LAUNCH edge.
- Latency: req_pulse at cycle 0 with everything idle gives pending visible at cycle 1 and tx_start=1 at cycle 2.
- Back-to-back throughput: tx_done at cycle T gives the next tx_start at T+GAP_CYCLES+2. With GAP_CYCLES=0, it is T+2.
- Width rules:
  - Gap counter width is $clog2(GAP_CYCLES+1), minimum 1.
  - Pointer wraps from NUM_REQ-1 to 0.

Test Plan:
- Reset: rst_n=0 for 3 cycles with req_pulse=4'b1111 → pending=0, tx_start=0, grant_id=0, tx_data=0, drop_pulse=0. Release reset, pulse req 2 with 8'hA5 → tx_start at +2 cycles, tx_data=8'hA5, grant_id=2.
- Fairness: pulse all 4 requests (bytes 8'h10, 8'h11, 8'h12, 8'h13) in one cycle. Model transmitter returns tx_done 10 cycles after start, GAP_CYCLES=16 → grants 0,1,2,3 in order. Consecutive tx_start pulses are exactly 28 cycles apart.
- Drop: pulse req 1 (8'h55) while req 1 is pending and not launching → drop_pulse high for exactly one cycle. Launched byte stays 8'h55 when the later pulse carries 8'hAA.
- Re-request at launch: pulse req 0 with 8'h77 in the LAUNCH cycle of req 0's 8'h66 frame → no drop. Frame sends 8'h66, pending[0]=1 afterwards, next frame sends 8'h77.
- Busy hold-off: hold tx_busy=1 with pending=4'b0001 for 50 cycles → no tx_start. tx_start occurs 1 cycle after tx_busy falls.
- Mid-frame reset: assert rst_n=0 in WAIT_DONE with pending=4'b0110 → pending=0 and state IDLE. A tx_done arriving later produces no tx_start.
